// File: rtl/capture_seq_pkg.sv
// Shared types and helpers for the capture round-robin sequencer.
//   state_t    : sequencer FSM states
//   wrap_inc   : pointer increment that wraps n-1 -> 0 for any n (not just powers of 2)
//   hold_width : width of the hold counter for a given HOLD_CYCLES
package capture_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned hold_width(input int unsigned hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/capture_rr_sequencer_if.sv
// Requester-side bus of the capture sequencer.
// Handshake: a requester raises req[i] (with its data slice in req_data) and
// holds it until it sees ack[i]; ack[i] and cap_en[i] pulse together for one
// cycle while gnt[i] is still high. Dropping req[i] before ack aborts the grant.
//   master : requester bank (drives enable/req/req_data)
//   slave  : sequencer (drives gnt/ack/cap_en/cap_data/busy/abort)
interface capture_rr_sequencer_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 1
);
  logic                      enable;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        cap_en;
  logic [DATA_W-1:0]         cap_data;
  logic                      busy;
  logic                      abort;

  modport master (
    output enable, req, req_data,
    input  gnt, ack, cap_en, cap_data, busy, abort
  );

  modport slave (
    input  enable, req, req_data,
    output gnt, ack, cap_en, cap_data, busy, abort
  );
endinterface

// File: rtl/capture_rr_sequencer_rr_pick.sv
// Combinational rotating-priority picker.
//   i_req    : request vector
//   i_rr_ptr : highest-priority index this round
//   o_valid  : any request present
//   o_winner : first requesting index scanning i_rr_ptr, i_rr_ptr+1, ... with wrap
module capture_rr_sequencer_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [PTR_W-1:0]   o_winner
);

  // Scan from the farthest offset down to offset 0 so the nearest request
  // to the pointer is the last (and therefore final) assignment.
  always_comb begin : scan
    int unsigned w_idx;
    o_valid  = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = int'(i_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (i_req[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = PTR_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/capture_rr_sequencer.sv
// Round-robin sequencer sharing one capture datapath among NUM_REQ requesters.
// Grants one requester, holds the grant HOLD_CYCLES cycles for path settling,
// then pulses cap_en/ack for one cycle with the winner's data slice.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : requester bus (slave side)
//   o_state    : current FSM state (debug)
//   o_rr_ptr   : current round-robin pointer (debug)
module capture_rr_sequencer
  import capture_seq_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  capture_rr_sequencer_if.slave        bus,
  output state_t                       o_state,
  output logic [$clog2(NUM_REQ)-1:0]   o_rr_ptr
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = hold_width(HOLD_CYCLES);

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [PTR_W-1:0]    r_winner, w_winner_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]  r_cap_en, w_cap_en_nxt;
  logic [DATA_W-1:0]   r_cap_data, w_cap_data_nxt;
  logic                r_abort, w_abort_nxt;

  logic                w_pick_valid;
  logic [PTR_W-1:0]    w_pick;
  logic [DATA_W-1:0]   w_sel_data;

  capture_rr_sequencer_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick)
  );

  assign w_sel_data = bus.req_data[int'(r_winner)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_winner   <= '0;
      r_gnt      <= '0;
      r_ack      <= '0;
      r_cap_en   <= '0;
      r_cap_data <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_winner   <= w_winner_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ack      <= w_ack_nxt;
      r_cap_en   <= w_cap_en_nxt;
      r_cap_data <= w_cap_data_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

  // Pulse outputs (ack, cap_en, cap_data, abort) default to 0 so they last
  // exactly one cycle; cap_data is therefore 0 whenever cap_en is 0.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_nxt     = r_hold_cnt;
    w_winner_nxt   = r_winner;
    w_gnt_nxt      = r_gnt;
    w_ack_nxt      = '0;
    w_cap_en_nxt   = '0;
    w_cap_data_nxt = '0;
    w_abort_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.enable && w_pick_valid) begin
          w_state_nxt  = GRANT;
          w_winner_nxt = w_pick;
          w_gnt_nxt    = NUM_REQ'(1) << w_pick;
          w_hold_nxt   = HOLD_W'(HOLD_CYCLES - 1);
        end
      end
      GRANT: begin
        if (!bus.req[r_winner]) begin
          w_state_nxt  = IDLE;
          w_abort_nxt  = 1'b1;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = PTR_W'(wrap_inc(int'(r_winner), NUM_REQ));
        end else if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end else begin
          // Capture strobes are registered here so they appear in CAPTURE.
          w_state_nxt    = CAPTURE;
          w_cap_en_nxt   = r_gnt;
          w_ack_nxt      = r_gnt;
          w_cap_data_nxt = w_sel_data;
        end
      end
      CAPTURE: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_rr_ptr_nxt = PTR_W'(wrap_inc(int'(r_winner), NUM_REQ));
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign bus.gnt      = r_gnt;
  assign bus.ack      = r_ack;
  assign bus.cap_en   = r_cap_en;
  assign bus.cap_data = r_cap_data;
  assign bus.abort    = r_abort;
  assign bus.busy     = (r_state != IDLE);
  assign o_state      = r_state;
  assign o_rr_ptr     = r_rr_ptr;

endmodule

// File: tb/tb_capture_rr_sequencer.sv
module tb_capture_rr_sequencer;
  import capture_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst3_n = 1'b0;
  logic rst5_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  capture_rr_sequencer_if #(.NUM_REQ(3), .DATA_W(1)) bus3();
  capture_rr_sequencer_if #(.NUM_REQ(5), .DATA_W(1)) bus5();

  state_t     st3, st5;
  logic [1:0] ptr3;
  logic [2:0] ptr5;

  capture_rr_sequencer #(.NUM_REQ(3), .DATA_W(1), .HOLD_CYCLES(2)) dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(bus3), .o_state(st3), .o_rr_ptr(ptr3)
  );

  capture_rr_sequencer #(.NUM_REQ(5), .DATA_W(1), .HOLD_CYCLES(1)) dut5 (
    .clk(clk), .rst_n(rst5_n), .bus(bus5), .o_state(st5), .o_rr_ptr(ptr5)
  );

  // ---------------- driver tasks ----------------
  // After tick we sit 1 ns past the edge: outputs show the new cycle and any
  // input driven now is sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset3();
    rst3_n = 1'b0;
    bus3.enable = 1'b1;
    bus3.req = '0;
    bus3.req_data = '0;
    tick();
    tick();
    rst3_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset3();
    n_tests++;
    if ({bus3.gnt, bus3.ack, bus3.cap_en, bus3.cap_data, bus3.busy, bus3.abort} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b ack=%b cap_en=%b cap_data=%b busy=%b abort=%b, want all 0",
               bus3.gnt, bus3.ack, bus3.cap_en, bus3.cap_data, bus3.busy, bus3.abort);
    end
    n_tests++;
    if (st3 !== IDLE || ptr3 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d ptr=%0d, want 0 0", st3, ptr3);
    end
  endtask

  task automatic test_single();
    bus3.req = 3'b001;
    bus3.req_data = 3'b001;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_tests++;
      if (bus3.gnt !== 3'b001 || bus3.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_gnt_c%0d: got gnt=%b busy=%b, want 001 1", c, bus3.gnt, bus3.busy);
      end
      n_tests++;
      if (bus3.cap_en !== ((c == 3) ? 3'b001 : 3'b000) || bus3.ack !== bus3.cap_en) begin
        n_fail++;
        $display("FAIL single_cap_c%0d: got cap_en=%b ack=%b, want %b", c, bus3.cap_en, bus3.ack,
                 (c == 3) ? 3'b001 : 3'b000);
      end
    end
    n_tests++;
    if (bus3.cap_data !== 1'b1) begin
      n_fail++;
      $display("FAIL single_cap_data: got %b want 1", bus3.cap_data);
    end
    bus3.req = '0;
    tick();
    n_tests++;
    if (bus3.gnt !== 3'b000 || bus3.busy !== 1'b0 || bus3.cap_en !== 3'b000 ||
        bus3.cap_data !== 1'b0 || ptr3 !== 2'd1) begin
      n_fail++;
      $display("FAIL single_done: got gnt=%b busy=%b cap_en=%b cap_data=%b ptr=%0d, want 000 0 000 0 1",
               bus3.gnt, bus3.busy, bus3.cap_en, bus3.cap_data, ptr3);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] data_v;
    do_reset3();
    data_v = 3'b101;
    bus3.req = 3'b111;
    bus3.req_data = data_v;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (bus3.gnt !== (3'b001 << k)) begin
        n_fail++;
        $display("FAIL b2b_gnt_%0d: got %b want %b", k, bus3.gnt, 3'b001 << k);
      end
      tick();
      tick();
      n_tests++;
      if (bus3.cap_en !== (3'b001 << k) || bus3.cap_data !== data_v[k]) begin
        n_fail++;
        $display("FAIL b2b_cap_%0d: got cap_en=%b data=%b want %b %b", k, bus3.cap_en,
                 bus3.cap_data, 3'b001 << k, data_v[k]);
      end
      bus3.req[k] = 1'b0;
      tick();
      n_tests++;
      if (bus3.busy !== 1'b0 || bus3.gnt !== 3'b000) begin
        n_fail++;
        $display("FAIL b2b_idle_%0d: got busy=%b gnt=%b want 0 000", k, bus3.busy, bus3.gnt);
      end
    end
    n_tests++;
    if (ptr3 !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_ptr_wrap: got %0d want 0", ptr3);
    end
  endtask

  task automatic test_abort();
    do_reset3();
    bus3.req = 3'b001;
    tick();                       // c1
    n_tests++;
    if (bus3.gnt !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_gnt: got %b want 001", bus3.gnt);
    end
    tick();                       // c2: drop winner, raise req1
    bus3.req = 3'b010;
    tick();                       // c3
    n_tests++;
    if (bus3.abort !== 1'b1 || bus3.gnt !== 3'b000 || bus3.cap_en !== 3'b000 ||
        bus3.ack !== 3'b000 || bus3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pulse: got abort=%b gnt=%b cap_en=%b ack=%b busy=%b want 1 000 000 000 0",
               bus3.abort, bus3.gnt, bus3.cap_en, bus3.ack, bus3.busy);
    end
    bus3.req = 3'b011;
    tick();                       // c4
    n_tests++;
    if (bus3.gnt !== 3'b010 || bus3.abort !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_rr: got gnt=%b abort=%b want 010 0", bus3.gnt, bus3.abort);
    end
    tick();
    tick();                       // c6 capture
    n_tests++;
    if (bus3.cap_en !== 3'b010) begin
      n_fail++;
      $display("FAIL abort_next_cap: got %b want 010", bus3.cap_en);
    end
    bus3.req = '0;
    tick();
  endtask

  task automatic test_enable();
    do_reset3();
    bus3.enable = 1'b0;
    bus3.req = 3'b010;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_tests++;
      if (bus3.gnt !== 3'b000 || bus3.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_off_c%0d: got gnt=%b busy=%b want 000 0", c, bus3.gnt, bus3.busy);
      end
    end
    bus3.enable = 1'b1;
    tick();                       // c1
    n_tests++;
    if (bus3.gnt !== 3'b010) begin
      n_fail++;
      $display("FAIL enable_on_gnt: got %b want 010", bus3.gnt);
    end
    tick();                       // c2
    bus3.enable = 1'b0;
    tick();                       // c3
    n_tests++;
    if (bus3.cap_en !== 3'b010 || bus3.ack !== 3'b010) begin
      n_fail++;
      $display("FAIL enable_drop_cap: got cap_en=%b ack=%b want 010 010", bus3.cap_en, bus3.ack);
    end
    tick();                       // c4: enable low, req still high -> no new grant
    tick();
    n_tests++;
    if (bus3.gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL enable_drop_idle: got gnt=%b want 000", bus3.gnt);
    end
    bus3.req = '0;
    bus3.enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset3();
    bus3.req = 3'b001;
    for (int c = 0; c < 4; c++) tick();  // full transaction, ptr -> 1
    bus3.req = 3'b010;
    tick();                       // c1
    n_tests++;
    if (bus3.gnt !== 3'b010 || ptr3 !== 2'd1) begin
      n_fail++;
      $display("FAIL mrst_gnt: got gnt=%b ptr=%0d want 010 1", bus3.gnt, ptr3);
    end
    tick();                       // c2
    rst3_n = 1'b0;
    tick();                       // c3
    rst3_n = 1'b1;
    n_tests++;
    if ({bus3.gnt, bus3.ack, bus3.cap_en, bus3.cap_data, bus3.busy, bus3.abort} !== 12'b0 ||
        ptr3 !== 2'd0 || st3 !== IDLE) begin
      n_fail++;
      $display("FAIL mrst_clear: got gnt=%b ack=%b cap_en=%b busy=%b abort=%b ptr=%0d state=%0d want all 0",
               bus3.gnt, bus3.ack, bus3.cap_en, bus3.busy, bus3.abort, ptr3, st3);
    end
    bus3.req = 3'b011;
    tick();                       // c4
    n_tests++;
    if (bus3.gnt !== 3'b001 || bus3.ack !== 3'b000 || bus3.abort !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_rearb: got gnt=%b ack=%b abort=%b want 001 000 0", bus3.gnt, bus3.ack, bus3.abort);
    end
    tick();
    tick();
    n_tests++;
    if (bus3.cap_en !== 3'b001) begin
      n_fail++;
      $display("FAIL mrst_cap: got %b want 001", bus3.cap_en);
    end
    bus3.req = '0;
    tick();
  endtask

  task automatic test_five_req();
    int exp_w;
    bus5.enable = 1'b1;
    bus5.req = '0;
    bus5.req_data = 5'b10000;
    rst5_n = 1'b0;
    tick();
    tick();
    rst5_n = 1'b1;
    bus5.req = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 0 : 4;
      tick();                     // grant cycle
      n_tests++;
      if (bus5.gnt !== (5'b00001 << exp_w)) begin
        n_fail++;
        $display("FAIL five_gnt_%0d: got %b want %b", k, bus5.gnt, 5'b00001 << exp_w);
      end
      tick();                     // capture cycle
      n_tests++;
      if (bus5.cap_en !== (5'b00001 << exp_w) || bus5.cap_data !== ((exp_w == 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL five_cap_%0d: got cap_en=%b data=%b want %b %b", k, bus5.cap_en,
                 bus5.cap_data, 5'b00001 << exp_w, (exp_w == 4) ? 1'b1 : 1'b0);
      end
      tick();                     // idle cycle
      n_tests++;
      if (ptr5 !== ((exp_w == 4) ? 3'd0 : 3'd1) || bus5.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL five_ptr_%0d: got ptr=%0d busy=%b want %0d 0", k, ptr5, bus5.busy,
                 (exp_w == 4) ? 0 : 1);
      end
    end
    bus5.req = '0;
    tick();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    bus3.enable = 1'b0;
    bus3.req = '0;
    bus3.req_data = '0;
    bus5.enable = 1'b0;
    bus5.req = '0;
    bus5.req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_enable();
    test_mid_reset();
    test_five_req();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
